keypad_to_reg: RTL and testbench

- Input-side counterpart of the seven-segment register display: a 4x4 matrix keypad entry block.
- Scans the keypad, synchronises and debounces presses, and accumulates up to 4 decimal digits into a binary value.
- Hands the value to the CPU I/O register file with a valid/ack handshake.
- Exports the BCD digits being typed so the display driver can echo them.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner.sv | 76 +++++++
 rtl/keypad_to_reg.sv | 153 +++++++++++++++
 tb/tb_keypad_to_reg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key indices, key-to-digit map and debounce FSM encoding for the keypad entry block.
// Latency: n/a (constants and one combinational helper).
// Backpressure: n/a.
package keypad_pkg;

  // Scan result index is row*4+col; the 5th bit marks "no key".
  localparam logic [4:0] KEY_CLEAR = 5'd12;
  localparam logic [4:0] KEY_ENTER = 5'd14;
  localparam logic [4:0] KEY_NONE  = 5'd31;

  localparam int MAX_DIGITS = 4;

  // Digit value per key index, 4'hF for keys that are not decimal digits.
  // Nibble i holds index i: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D.
  localparam logic [3:0]  NO_DIGIT      = 4'hF;
  localparam logic [63:0] KEY_DIGIT_MAP = 64'hFF0F_F987_F654_F321;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  function automatic logic [3:0] key_digit(input logic [3:0] idx);
    logic [63:0] map;
    map = KEY_DIGIT_MAP;
    return map[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Drives keypad columns, synchronises rows, reports the lowest pressed key index once per full scan.
// Latency: one scan_vld pulse per 4*SCAN_DIV cycles; rows reach the sampler through 2 flops.
// Backpressure: none; scan_vld is a single-cycle strobe that must be consumed when presented.
// Ports: clock, reset (sync, active-high), enable, kp_row (active-low, async),
//        kp_col (active-low one-hot drive), scan_key (row*4+col or KEY_NONE), scan_vld.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic [4:0] scan_key,
  output logic       scan_vld
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] step;
  logic [1:0]    col;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [4:0]    best;      // lowest index seen so far in the current scan
  logic [4:0]    col_hit;   // lowest index pressed in the active column
  logic [4:0]    merged;
  logic          last_step;

  assign last_step = (step == SW'(SCAN_DIV - 1));
  assign kp_col    = enable ? ~(4'b0001 << col) : 4'b1111;

  // Walk rows high to low so the lowest pressed row wins.
  always_comb begin
    col_hit = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) col_hit = {1'b0, 2'(r), col};
    end
    merged = (col_hit < best) ? col_hit : best;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      step     <= '0;
      col      <= 2'd0;
      best     <= KEY_NONE;
      scan_key <= KEY_NONE;
      scan_vld <= 1'b0;
    end else begin
      row_meta <= kp_row;
      row_sync <= row_meta;
      scan_vld <= 1'b0;
      if (!enable) begin
        step <= '0;
        col  <= 2'd0;
        best <= KEY_NONE;
      end else if (last_step) begin
        step <= '0;
        col  <= col + 2'd1;
        if (col == 2'd3) begin
          scan_key <= merged;
          scan_vld <= 1'b1;
          best     <= KEY_NONE;
        end else begin
          best <= merged;
        end
      end else begin
        step <= step + SW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_to_reg.sv
// Keypad entry: debounces scan results, accumulates up to 4 decimal digits, hands the value to the CPU.
// Latency: a press acts one cycle after the scan result that completes its debounce.
// Backpressure: data_valid/data_ack; an ENTER while a value is pending overwrites it and sets sticky overrun.
// Ports: clock, reset (sync, active-high), enable, kp_row/kp_col (keypad matrix, active-low),
//        data_out/data_valid/data_ack/overrun (CPU side), bcd_digits/digit_count (display echo).
module keypad_to_reg
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  kp_row,
  output logic [3:0]  kp_col,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ack,
  output logic        overrun,
  output logic [15:0] bcd_digits,
  output logic [2:0]  digit_count
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int VW = 14;  // 9999 is the largest 4-digit value

  logic [4:0]    scan_key;
  logic          scan_vld;
  key_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0]    cand, cand_n;
  logic          accept;
  logic          key_present;
  logic [3:0]    digit;
  logic [VW-1:0] value;
  logic [VW-1:0] out_val;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .kp_row   (kp_row),
    .kp_col   (kp_col),
    .scan_key (scan_key),
    .scan_vld (scan_vld)
  );

  assign key_present = (scan_key != KEY_NONE);
  assign cnt_inc     = cnt + CW'(1);
  assign digit       = key_digit(scan_key[3:0]);
  assign data_out    = {{(32 - VW){1'b0}}, out_val};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (!enable) begin
      // Pretend a key is being released so anything held across the enable edge must go up first.
      state_n = REL_DB;
      cnt_n   = '0;
    end else if (scan_vld) begin
      case (state)
        IDLE: begin
          if (key_present) begin
            cand_n = scan_key;
            cnt_n  = CW'(1);
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (scan_key == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (!key_present) begin
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE == 1) ? IDLE : REL_DB;
          end
        end
        REL_DB: begin
          if (key_present) begin
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE)) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= KEY_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // Accept only fires on the debounce-completing result, which always carries the accepted key.
  always_ff @(posedge clock) begin
    if (reset) begin
      value       <= '0;
      bcd_digits  <= '0;
      digit_count <= '0;
      out_val     <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (data_ack && data_valid) data_valid <= 1'b0;
      if (accept) begin
        if (scan_key == KEY_CLEAR) begin
          value       <= '0;
          bcd_digits  <= '0;
          digit_count <= '0;
        end else if (scan_key == KEY_ENTER) begin
          out_val     <= value;
          data_valid  <= 1'b1;  // wins over a same-cycle ack
          if (data_valid && !data_ack) overrun <= 1'b1;
          value       <= '0;
          bcd_digits  <= '0;
          digit_count <= '0;
        end else if (digit != NO_DIGIT && digit_count < 3'(MAX_DIGITS)) begin
          value       <= value * VW'(10) + {{(VW - 4){1'b0}}, digit};
          bcd_digits  <= {bcd_digits[11:0], digit};
          digit_count <= digit_count + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_to_reg.sv
// Bench for keypad_to_reg with SCAN_DIV=4, DEBOUNCE=2 (16 cycles per full scan).
// A keypad model pulls a row low while its key's column is driven; expected outputs go into a queue.
// A monitor pops and compares whenever the observable output tuple changes.
module tb_keypad_to_reg;

  localparam logic [4:0] K0 = 5'd13, K1 = 5'd0, K2 = 5'd1, K3 = 5'd2, K4 = 5'd4, K5 = 5'd5;
  localparam logic [4:0] K6 = 5'd6, K7 = 5'd8, K8 = 5'd9, K9 = 5'd10;
  localparam logic [4:0] KSTAR = 5'd12, KHASH = 5'd14, KNONE = 5'd31;

  typedef struct packed {
    logic [31:0] dout;
    logic        dv;
    logic        ovr;
    logic [15:0] bcd;
    logic [2:0]  cnt;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ack;
  logic        overrun;
  logic [15:0] bcd_digits;
  logic [2:0]  digit_count;

  logic [4:0]  pressed = KNONE;
  logic        mon_en = 1'b0;
  obs_t        sb[$];
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  keypad_to_reg #(
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .kp_row      (kp_row),
    .kp_col      (kp_col),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .overrun     (overrun),
    .bcd_digits  (bcd_digits),
    .digit_count (digit_count)
  );

  always_comb begin
    kp_row = 4'hF;
    if (pressed != KNONE && kp_col[pressed[1:0]] == 1'b0) kp_row[pressed[3:2]] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_obs(input logic [31:0] dout, input logic dv, input logic ovr,
                            input logic [15:0] bcd, input logic [2:0] cnt);
    obs_t o;
    o.dout = dout; o.dv = dv; o.ovr = ovr; o.bcd = bcd; o.cnt = cnt;
    sb.push_back(o);
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation.
  initial begin
    obs_t cur, prev, exp;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = {data_out, data_valid, overrun, bcd_digits, digit_count};
      if (mon_en && cur != prev) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got dout=%0d dv=%0b ovr=%0b bcd=%h cnt=%0d, expected no change",
                   cur.dout, cur.dv, cur.ovr, cur.bcd, cur.cnt);
        end else begin
          exp = sb.pop_front();
          if (cur == exp) n_pass++;
          else $display("FAIL sb_compare: got dout=%0d dv=%0b ovr=%0b bcd=%h cnt=%0d, expected dout=%0d dv=%0b ovr=%0b bcd=%h cnt=%0d",
                        cur.dout, cur.dv, cur.ovr, cur.bcd, cur.cnt,
                        exp.dout, exp.dv, exp.ovr, exp.bcd, exp.cnt);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic press(input logic [4:0] k, input int on_scans, input int off_scans);
    @(negedge clock);
    pressed = k;
    repeat (on_scans * 16) @(negedge clock);
    pressed = KNONE;
    repeat (off_scans * 16) @(negedge clock);
  endtask

  // Returns at the negedge of the first cycle after a scan result strobe (kp_col back to 1110).
  task automatic wait_scan_start();
    logic [3:0] last;
    logic       found;
    last  = kp_col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (kp_col == 4'b1110 && last != 4'b1110) found = 1'b1;
      last = kp_col;
    end
    if (!found) check("scan_wait", 32'(found), 32'd1);
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
  endtask

  // ENTER pressed at a scan start is accepted on the second following result; ack that exact cycle.
  task automatic enter_with_ack();
    wait_scan_start();
    pressed = KHASH;
    wait_scan_start();
    wait_scan_start();
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
    pressed  = KNONE;
    repeat (48) @(negedge clock);
  endtask

  initial begin
    logic [3:0] col_seq [4];
    logic       found;
    col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
    reset = 1'b1; enable = 1'b1; data_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_kp_col", 32'(kp_col), 32'hE);
    check("rst_data_out", data_out, 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_bcd", 32'(bcd_digits), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Column drive walks 1110 -> 1101 -> 1011 -> 0111, four cycles each.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (kp_col == 4'b1101) found = 1'b1;
    end
    check("col_first_step", 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("col_cycle", 32'(kp_col), 32'(col_seq[i / 4]));
      @(negedge clock);
    end

    // One-scan glitch on 7 is rejected; a three-scan press of 5 is accepted once.
    press(K7, 1, 3);
    expect_obs(0, 0, 0, 16'h0005, 1);
    press(K5, 3, 3);

    // Clear, then 1 2 3 4 5 #: fifth digit dropped, 1234 delivered.
    expect_obs(0, 0, 0, 16'h0000, 0);
    press(KSTAR, 3, 3);
    expect_obs(0, 0, 0, 16'h0001, 1); press(K1, 3, 3);
    expect_obs(0, 0, 0, 16'h0012, 2); press(K2, 3, 3);
    expect_obs(0, 0, 0, 16'h0123, 3); press(K3, 3, 3);
    expect_obs(0, 0, 0, 16'h1234, 4); press(K4, 3, 3);
    press(K5, 3, 3);
    expect_obs(32'h4D2, 1, 0, 16'h0000, 0); press(KHASH, 3, 3);

    // ENTER coincident with ack while 1234 pending: 42 replaces it, valid stays, no overrun.
    expect_obs(1234, 1, 0, 16'h0004, 1); press(K4, 3, 3);
    expect_obs(1234, 1, 0, 16'h0042, 2); press(K2, 3, 3);
    expect_obs(42, 1, 0, 16'h0000, 0);   enter_with_ack();

    // ENTER 7 without ack while 42 pending: overrun.
    expect_obs(42, 1, 0, 16'h0007, 1); press(K7, 3, 3);
    expect_obs(7, 1, 1, 16'h0000, 0);  press(KHASH, 3, 3);
    expect_obs(7, 0, 1, 16'h0000, 0);  ack_pulse();
    ack_pulse();  // ack with nothing pending changes nothing
    repeat (4) @(negedge clock);
    expect_obs(7, 0, 1, 16'h0009, 1);  press(K9, 3, 3);
    expect_obs(9, 1, 1, 16'h0000, 0);  enter_with_ack();

    // 8 6 * then # delivers 0.
    expect_obs(9, 1, 1, 16'h0008, 1); press(K8, 3, 3);
    expect_obs(9, 1, 1, 16'h0086, 2); press(K6, 3, 3);
    expect_obs(9, 1, 1, 16'h0000, 0); press(KSTAR, 3, 3);
    expect_obs(0, 1, 1, 16'h0000, 0); press(KHASH, 3, 3);

    // Key held across enable rising is never accepted; after release it is.
    @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check("dis_kp_col", 32'(kp_col), 32'hF);
    pressed = K3;
    repeat (10) @(negedge clock);
    check("dis_kp_col_held", 32'(kp_col), 32'hF);
    enable = 1'b1;
    repeat (80) @(negedge clock);
    pressed = KNONE;
    repeat (32) @(negedge clock);
    expect_obs(0, 1, 1, 16'h0003, 1); press(K3, 3, 3);

    // Reset mid-debounce with a value pending.
    wait_scan_start();
    pressed = K5;
    wait_scan_start();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    check("mid_rst_kp_col", 32'(kp_col), 32'hE);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_data_valid", 32'(data_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_bcd", 32'(bcd_digits), 32'd0);
    check("mid_rst_count", 32'(digit_count), 32'd0);
    pressed = KNONE;
    reset   = 1'b0;
    repeat (2) @(negedge clock);
    mon_en = 1'b1;
    repeat (48) @(negedge clock);
    expect_obs(0, 0, 0, 16'h0000, 1); press(K0, 3, 3);

    repeat (20) @(negedge clock);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
